// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: fetch FSM states and default word/address sizes.
// Decode imports the same widths, so changing them here keeps both stages consistent.
package pipeline_pkg;

  localparam int DEFAULT_ADDR_WIDTH        = 32;
  localparam int DEFAULT_INSTRUCTION_WIDTH = 32;

  localparam logic [DEFAULT_INSTRUCTION_WIDTH-1:0] NOP_WORD          = '0;
  localparam logic [DEFAULT_INSTRUCTION_WIDTH-1:0] DEFAULT_HALT_WORD = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory port between the fetch stage (master) and a combinational-read memory.
interface imem_if #(
  parameter int ADDR_WIDTH        = pipeline_pkg::DEFAULT_ADDR_WIDTH,
  parameter int INSTRUCTION_WIDTH = pipeline_pkg::DEFAULT_INSTRUCTION_WIDTH
);

  logic [ADDR_WIDTH-1:0]        imem_address;
  logic [INSTRUCTION_WIDTH-1:0] imem_instruction;

  modport master (
    output imem_address,
    input  imem_instruction
  );

  modport slave (
    input  imem_address,
    output imem_instruction
  );

endinterface

// File: rtl/fetch_stage_sat_counter.sv
// Saturating up-counter with async active-low reset and a synchronous clear.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Stage-1 instruction fetch: PC, IF/ID register, stall/redirect/halt handling.
// Optional performance counters are enabled by defining FETCH_PERF_CNT_EN.
module fetch_stage
  import pipeline_pkg::*;
#(
  parameter int                           ADDR_WIDTH        = DEFAULT_ADDR_WIDTH,
  parameter int                           INSTRUCTION_WIDTH = DEFAULT_INSTRUCTION_WIDTH,
  parameter int                           PC_STEP           = 4,
  parameter logic [ADDR_WIDTH-1:0]        RESET_PC          = '0,
  parameter logic [INSTRUCTION_WIDTH-1:0] HALT_WORD         = INSTRUCTION_WIDTH'(DEFAULT_HALT_WORD)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         stall,
  input  logic                         branch_taken,
  input  logic [ADDR_WIDTH-1:0]        branch_target,
  imem_if.master                       imem,
  output logic [INSTRUCTION_WIDTH-1:0] if_instruction,
  output logic [ADDR_WIDTH-1:0]        if_pc,
  output logic                         if_valid,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]                  perf_fetched,
  output logic [31:0]                  perf_squashed,
  output logic [31:0]                  perf_stalled,
`endif
  output logic                         halted
);

  localparam logic [INSTRUCTION_WIDTH-1:0] NOP = INSTRUCTION_WIDTH'(NOP_WORD);

  fetch_state_t          state;
  logic [ADDR_WIDTH-1:0] pc;

  assign imem.imem_address = pc;
  assign halted            = (state == HALT);

  // Branch always wins over stall so a squash from a later stage is never dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= BOOT;
      pc             <= RESET_PC;
      if_instruction <= NOP;
      if_pc          <= '0;
      if_valid       <= 1'b0;
    end else begin
      case (state)
        BOOT: begin
          state <= RUN;
        end
        RUN: begin
          if (branch_taken) begin
            pc             <= branch_target;
            if_instruction <= NOP;
            if_valid       <= 1'b0;
          end else if (!stall) begin
            if_instruction <= imem.imem_instruction;
            if_pc          <= pc;
            if_valid       <= 1'b1;
            if (imem.imem_instruction == HALT_WORD) begin
              state <= HALT;
            end else begin
              pc <= pc + ADDR_WIDTH'(PC_STEP);
            end
          end
        end
        HALT: begin
          if (branch_taken) begin
            pc             <= branch_target;
            if_instruction <= NOP;
            if_valid       <= 1'b0;
            state          <= RUN;
          end else if (!stall) begin
            if_instruction <= NOP;
            if_valid       <= 1'b0;
          end
        end
        default: begin
          state <= BOOT;
        end
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic fetch_inc;
  logic squash_inc;
  logic stall_inc;

  assign fetch_inc  = (state == RUN) && !branch_taken && !stall;
  assign squash_inc = (state != BOOT) && branch_taken;
  assign stall_inc  = (state != BOOT) && stall && !branch_taken;

  sat_counter #(.WIDTH(32)) u_fetched_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (1'b0),
    .inc   (fetch_inc),
    .count (perf_fetched)
  );

  sat_counter #(.WIDTH(32)) u_squashed_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (1'b0),
    .inc   (squash_inc),
    .count (perf_squashed)
  );

  sat_counter #(.WIDTH(32)) u_stalled_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (1'b0),
    .inc   (stall_inc),
    .count (perf_stalled)
  );
`endif

endmodule
